// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_W_DEFAULT = 4;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell: diff = x - y - bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial d = a - b, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow; start/done handshake.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = SUB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         borrow,
    output logic         ovf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    sub_state_t    state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
    logic          bflop;
    logic          a_msb;
    logic          b_msb;
    logic          diff_bit;
    logic          bout_bit;

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bflop),
        .diff (diff_bit),
        .bout (bout_bit)
    );

    // FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            bflop  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        a_msb <= a[W-1];
                        b_msb <= b[W-1];
                        bflop <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    res   <= {diff_bit, res[W-1:1]};
                    a_sh  <= {1'b0, a_sh[W-1:1]};
                    b_sh  <= {1'b0, b_sh[W-1:1]};
                    bflop <= bout_bit;
                    // The last bit loads results directly so they appear with done.
                    if (cnt == LAST) begin
                        d      <= {diff_bit, res[W-1:1]};
                        borrow <= bout_bit;
                        ovf    <= (a_msb ^ b_msb) & (diff_bit ^ a_msb);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt    <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed W=4 vectors plus a back-to-back W=8 sweep.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start4, busy4, done4, borrow4, ovf4;
    logic [3:0] a4, b4, d4;
    logic       start8, busy8, done8, borrow8, ovf8;
    logic [7:0] a8, b8, d8;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .d(d4), .borrow(borrow4), .ovf(ovf4)
    );

    serial_subtractor #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .borrow(borrow8), .ovf(ovf8)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One W=4 operation with hand-computed expectations.
    task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] ed, input logic eb, input logic eo);
        int k;
        bit seen;
        @(negedge clk);
        a4 = av; b4 = bv; start4 = 1'b1;
        @(posedge clk); #1;
        expect_eq({tag, ".busy"}, 32'(busy4), 32'd1);
        @(negedge clk);
        start4 = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (done4) seen = 1'b1;
        end
        expect_eq({tag, ".latency"}, 32'(k), 32'd4);
        expect_eq({tag, ".d"}, 32'(d4), 32'(ed));
        expect_eq({tag, ".borrow"}, 32'(borrow4), 32'(eb));
        expect_eq({tag, ".ovf"}, 32'(ovf4), 32'(eo));
        expect_eq({tag, ".busy_at_done"}, 32'(busy4), 32'd0);
        @(posedge clk); #1;
        expect_eq({tag, ".done_pulse"}, 32'(done4), 32'd0);
    endtask

    initial begin
        int ndone;
        int k;
        bit seen;
        int last_cyc;
        int sa, sb, r;
        logic [7:0] ea, eb8;

        reset = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        expect_eq("rst.busy4", 32'(busy4), 32'd0);
        expect_eq("rst.done4", 32'(done4), 32'd0);
        expect_eq("rst.d4", 32'(d4), 32'd0);
        expect_eq("rst.borrow4", 32'(borrow4), 32'd0);
        expect_eq("rst.ovf4", 32'(ovf4), 32'd0);
        expect_eq("rst.busy8", 32'(busy8), 32'd0);
        expect_eq("rst.d8", 32'(d8), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        op4("9m3", 4'd9, 4'd3, 4'd6,  1'b1 ^ 1'b1, 1'b1);
        op4("3m9", 4'd3, 4'd9, 4'hA,  1'b1, 1'b1);
        op4("5m5", 4'd5, 4'd5, 4'd0,  1'b0, 1'b0);
        op4("8m1", 4'd8, 4'd1, 4'd7,  1'b0, 1'b1);
        op4("0m1", 4'd0, 4'd1, 4'hF,  1'b1, 1'b0);

        // Second start during RUN must be ignored.
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd9; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done4) ndone++;
        end
        expect_eq("ign.ndone", 32'(ndone), 32'd1);
        expect_eq("ign.d", 32'(d4), 32'd6);
        expect_eq("ign.borrow", 32'(borrow4), 32'd0);
        expect_eq("ign.ovf", 32'(ovf4), 32'd1);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        a4 = 4'd8; b4 = 4'd1; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        expect_eq("mrst.busy", 32'(busy4), 32'd0);
        expect_eq("mrst.done", 32'(done4), 32'd0);
        expect_eq("mrst.d", 32'(d4), 32'd0);
        expect_eq("mrst.ovf", 32'(ovf4), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done4) ndone++;
        end
        expect_eq("mrst.nodone", 32'(ndone), 32'd0);
        op4("post_rst", 4'd3, 4'd9, 4'hA, 1'b1, 1'b1);

        // W=8 back-to-back sweep with start held high.
        @(negedge clk);
        a8 = 8'($urandom_range(255, 0));
        b8 = 8'($urandom_range(255, 0));
        start8 = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            ea = a8; eb8 = b8;
            sa = int'($signed(ea));
            sb = int'($signed(eb8));
            r  = sa - sb;
            k = 0; seen = 1'b0;
            while (!seen && k < 30) begin
                @(posedge clk); #1;
                k++;
                if (done8) seen = 1'b1;
            end
            expect_eq("sw.seen", 32'(seen), 32'd1);
            expect_eq("sw.d", 32'(d8), 32'(8'(ea - eb8)));
            expect_eq("sw.borrow", 32'(borrow8), 32'(ea < eb8));
            expect_eq("sw.ovf", 32'(ovf8), 32'((r < -128) || (r > 127)));
            if (i > 0) expect_eq("sw.spacing", 32'(cyc - last_cyc), 32'd10);
            last_cyc = cyc;
            @(negedge clk);
            a8 = 8'($urandom_range(255, 0));
            b8 = 8'($urandom_range(255, 0));
        end
        start8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
